// File: rtl/efpga_op_sequencer.sv
// efpga_op_sequencer
// Arbitrates two requesters (0: core pipeline, 1: external data port) round-robin onto the
// shared eFPGA coprocessor port, launches each granted operation with a single write strobe,
// waits for fabric done / a fixed latency / a done-mode timeout, then returns the captured
// results to the owning requester with a one-cycle valid.
//
// Ports
//   clk_i, reset            clock; synchronous active-low reset
//   req_i[1:0]              per-requester request (level)
//   gnt_o[1:0]              one-hot grant, combinational, IDLE only
//   operand_a_i/_b_i[63:0]  requester k at [32k+31:32k]
//   operator_i[3:0]         requester k at [2k+1:2k]
//   delay_i[7:0]            requester k at [4k+3:4k]; 0 = done-mode
//   rvalid_o[1:0], err_o    one-cycle completion pulse to owner; err_o flags a timeout
//   result_a/b/c_o[31:0]    captured results, held until next capture
//   busy_o                  high outside IDLE
//   eFPGA_*_o               registered operands/operator/delay, enable, write strobe
//   eFPGA_result_*_i        fabric results; eFPGA_fpga_done_i completion (WAIT only)

module efpga_op_sequencer #(
    parameter int unsigned TIMEOUT_W = 8
) (
    input  logic        clk_i,
    input  logic        reset,
    input  logic [1:0]  req_i,
    output logic [1:0]  gnt_o,
    input  logic [63:0] operand_a_i,
    input  logic [63:0] operand_b_i,
    input  logic [3:0]  operator_i,
    input  logic [7:0]  delay_i,
    output logic [1:0]  rvalid_o,
    output logic        err_o,
    output logic [31:0] result_a_o,
    output logic [31:0] result_b_o,
    output logic [31:0] result_c_o,
    output logic        busy_o,
    output logic [31:0] eFPGA_operand_a_o,
    output logic [31:0] eFPGA_operand_b_o,
    output logic [1:0]  eFPGA_operator_o,
    output logic [3:0]  eFPGA_delay_o,
    output logic        eFPGA_en_o,
    output logic        eFPGA_write_strobe_o,
    input  logic [31:0] eFPGA_result_a_i,
    input  logic [31:0] eFPGA_result_b_i,
    input  logic [31:0] eFPGA_result_c_i,
    input  logic        eFPGA_fpga_done_i
);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

    localparam logic [31:0] TimeoutMax = 32'((64'd1 << TIMEOUT_W) - 64'd1);

    state_e               state_q, state_d;
    logic                 last_q;
    logic                 owner_q;
    logic [TIMEOUT_W-1:0] cnt_q;
    logic                 err_q;
    logic [31:0]          res_a_q, res_b_q, res_c_q;
    logic [31:0]          op_a_q, op_b_q;
    logic [1:0]           opr_q;
    logic [3:0]           dly_q;

    logic        winner;
    logic        grant;
    logic [31:0] cnt_inc;
    logic        fixed_hit;
    logic        timeout_hit;
    logic        complete;

    // Round-robin: on a tie the requester that did not win last time goes next.
    always_comb begin
        winner = 1'b0;
        case (req_i)
            2'b01:   winner = 1'b0;
            2'b10:   winner = 1'b1;
            2'b11:   winner = ~last_q;
            default: winner = 1'b0;
        endcase
    end

    assign grant = (state_q == StIdle) && reset && (req_i != 2'b00);
    assign gnt_o = grant ? (winner ? 2'b10 : 2'b01) : 2'b00;

    // Compare at 32 bits so a 4-bit delay is never truncated by a narrow counter.
    assign cnt_inc     = 32'(cnt_q) + 32'd1;
    assign fixed_hit   = (dly_q != 4'd0) && (cnt_inc == 32'(dly_q));
    assign timeout_hit = (dly_q == 4'd0) && (cnt_inc == TimeoutMax) && !eFPGA_fpga_done_i;
    assign complete    = (state_q == StWait) && (eFPGA_fpga_done_i || fixed_hit || timeout_hit);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (grant) state_d = StIssue;
            StIssue: state_d = StWait;
            StWait:  if (complete) state_d = StResp;
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!reset) begin
            state_q <= StIdle;
            last_q  <= 1'b1;
            owner_q <= 1'b0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            res_a_q <= '0;
            res_b_q <= '0;
            res_c_q <= '0;
            op_a_q  <= '0;
            op_b_q  <= '0;
            opr_q   <= '0;
            dly_q   <= '0;
        end else begin
            state_q <= state_d;
            if (grant) begin
                last_q  <= winner;
                owner_q <= winner;
                op_a_q  <= winner ? operand_a_i[63:32] : operand_a_i[31:0];
                op_b_q  <= winner ? operand_b_i[63:32] : operand_b_i[31:0];
                opr_q   <= winner ? operator_i[3:2] : operator_i[1:0];
                dly_q   <= winner ? delay_i[7:4] : delay_i[3:0];
            end
            if (state_q == StIssue) begin
                cnt_q <= '0;
            end else if (state_q == StWait) begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (complete) begin
                // Only a done-mode timeout reaches here with done low and delay zero.
                err_q   <= timeout_hit;
                res_a_q <= timeout_hit ? 32'd0 : eFPGA_result_a_i;
                res_b_q <= timeout_hit ? 32'd0 : eFPGA_result_b_i;
                res_c_q <= timeout_hit ? 32'd0 : eFPGA_result_c_i;
            end
        end
    end

    always_comb begin
        rvalid_o = 2'b00;
        err_o    = 1'b0;
        if (state_q == StResp) begin
            rvalid_o = owner_q ? 2'b10 : 2'b01;
            err_o    = err_q;
        end
    end

    assign busy_o               = (state_q != StIdle);
    assign eFPGA_en_o           = (state_q == StIssue) || (state_q == StWait);
    assign eFPGA_write_strobe_o = (state_q == StIssue);
    assign eFPGA_operand_a_o    = op_a_q;
    assign eFPGA_operand_b_o    = op_b_q;
    assign eFPGA_operator_o     = opr_q;
    assign eFPGA_delay_o        = dly_q;
    assign result_a_o           = res_a_q;
    assign result_b_o           = res_b_q;
    assign result_c_o           = res_c_q;

endmodule

// File: tb/tb_efpga_op_sequencer.sv
// Directed bench for efpga_op_sequencer with a small timeout width so the done-mode timeout is
// reachable. Expected completions are queued at grant time and popped when rvalid_o fires.

module tb_efpga_op_sequencer;

    logic        clk_i = 1'b0;
    logic        reset = 1'b0;
    logic [1:0]  req_i = 2'b00;
    logic [1:0]  gnt_o;
    logic [63:0] operand_a_i = '0;
    logic [63:0] operand_b_i = '0;
    logic [3:0]  operator_i = '0;
    logic [7:0]  delay_i = '0;
    logic [1:0]  rvalid_o;
    logic        err_o;
    logic [31:0] result_a_o, result_b_o, result_c_o;
    logic        busy_o;
    logic [31:0] eFPGA_operand_a_o, eFPGA_operand_b_o;
    logic [1:0]  eFPGA_operator_o;
    logic [3:0]  eFPGA_delay_o;
    logic        eFPGA_en_o, eFPGA_write_strobe_o;
    logic [31:0] eFPGA_result_a_i = '0;
    logic [31:0] eFPGA_result_b_i = '0;
    logic [31:0] eFPGA_result_c_i = '0;
    logic        eFPGA_fpga_done_i = 1'b0;

    efpga_op_sequencer #(.TIMEOUT_W(3)) dut (
        .clk_i                (clk_i),
        .reset                (reset),
        .req_i                (req_i),
        .gnt_o                (gnt_o),
        .operand_a_i          (operand_a_i),
        .operand_b_i          (operand_b_i),
        .operator_i           (operator_i),
        .delay_i              (delay_i),
        .rvalid_o             (rvalid_o),
        .err_o                (err_o),
        .result_a_o           (result_a_o),
        .result_b_o           (result_b_o),
        .result_c_o           (result_c_o),
        .busy_o               (busy_o),
        .eFPGA_operand_a_o    (eFPGA_operand_a_o),
        .eFPGA_operand_b_o    (eFPGA_operand_b_o),
        .eFPGA_operator_o     (eFPGA_operator_o),
        .eFPGA_delay_o        (eFPGA_delay_o),
        .eFPGA_en_o           (eFPGA_en_o),
        .eFPGA_write_strobe_o (eFPGA_write_strobe_o),
        .eFPGA_result_a_i     (eFPGA_result_a_i),
        .eFPGA_result_b_i     (eFPGA_result_b_i),
        .eFPGA_result_c_i     (eFPGA_result_c_i),
        .eFPGA_fpga_done_i    (eFPGA_fpga_done_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [1:0]  rv;
        logic        err;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   n_strobe = 0;
    int   n_en = 0;
    int   n_rvalid = 0;

    always @(posedge clk_i) begin
        cyc <= cyc + 1;
        if (eFPGA_write_strobe_o === 1'b1) n_strobe <= n_strobe + 1;
        if (eFPGA_en_o === 1'b1) n_en <= n_en + 1;
        if (rvalid_o !== 2'b00) n_rvalid <= n_rvalid + 1;
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [1:0] rv, input logic err, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] c);
        exp_t e;
        e.rv = rv;
        e.err = err;
        e.a = a;
        e.b = b;
        e.c = c;
        sb.push_back(e);
    endtask

    // Step until rvalid_o fires (bounded), then pop and compare the oldest expectation.
    task automatic wait_rv(input string tag, input int budget, input int exp_cyc);
        exp_t e;
        int   n;
        logic seen;
        n = 0;
        seen = 1'b0;
        while (!seen && n < budget) begin
            if (rvalid_o !== 2'b00) seen = 1'b1;
            else begin
                tick();
                n++;
            end
        end
        chk({tag, "_seen"}, 32'(seen), 32'd1);
        if (seen) begin
            chk({tag, "_cycle"}, 32'(cyc), 32'(exp_cyc));
            chk({tag, "_sb_nonempty"}, 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk({tag, "_rvalid"}, 32'(rvalid_o), 32'(e.rv));
                chk({tag, "_err"}, 32'(err_o), 32'(e.err));
                chk({tag, "_res_a"}, result_a_o, e.a);
                chk({tag, "_res_b"}, result_b_o, e.b);
                chk({tag, "_res_c"}, result_c_o, e.c);
            end
        end
    endtask

    int g;
    int snap;

    initial begin
        // Reset, with both requests high to show the grant is suppressed.
        req_i = 2'b11;
        tick();
        tick();
        chk("rst_gnt", 32'(gnt_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_en", 32'(eFPGA_en_o), 32'd0);
        chk("rst_strobe", 32'(eFPGA_write_strobe_o), 32'd0);
        chk("rst_rvalid", 32'(rvalid_o), 32'd0);
        chk("rst_err", 32'(err_o), 32'd0);
        chk("rst_res_a", result_a_o, 32'd0);
        chk("rst_op_a", eFPGA_operand_a_o, 32'd0);
        req_i = 2'b00;
        reset = 1'b1;
        tick();

        // Single op, done mode: done arrives in the third WAIT cycle.
        req_i = 2'b01;
        operand_a_i[31:0] = 32'd5;
        operand_b_i[31:0] = 32'd7;
        operator_i[1:0] = 2'd1;
        delay_i[3:0] = 4'd0;
        eFPGA_result_b_i = 32'hB0;
        eFPGA_result_c_i = 32'hC0;
        #1;
        chk("t1_gnt", 32'(gnt_o), 32'h1);
        g = cyc;
        snap = n_strobe;
        push(2'b01, 1'b0, 32'd12, 32'hB0, 32'hC0);
        tick();
        req_i = 2'b00;
        chk("t1_strobe", 32'(eFPGA_write_strobe_o), 32'd1);
        chk("t1_en", 32'(eFPGA_en_o), 32'd1);
        chk("t1_gnt_issue", 32'(gnt_o), 32'd0);
        chk("t1_op_a", eFPGA_operand_a_o, 32'd5);
        chk("t1_op_b", eFPGA_operand_b_o, 32'd7);
        chk("t1_operator", 32'(eFPGA_operator_o), 32'd1);
        tick();
        tick();
        tick();
        eFPGA_fpga_done_i = 1'b1;
        eFPGA_result_a_i = 32'd12;
        tick();
        eFPGA_fpga_done_i = 1'b0;
        wait_rv("t1", 10, g + 5);
        chk("t1_strobe_count", 32'(n_strobe - snap), 32'd1);
        tick();
        chk("t1_rvalid_drop", 32'(rvalid_o), 32'd0);
        chk("t1_busy_idle", 32'(busy_o), 32'd0);
        chk("t1_res_hold", result_a_o, 32'd12);

        // Fixed latency, requester 1, delay 4; results change up to the completion edge.
        req_i = 2'b10;
        operand_a_i[63:32] = 32'h1111_0001;
        operand_b_i[63:32] = 32'h2222_0002;
        operator_i[3:2] = 2'd2;
        delay_i[7:4] = 4'd4;
        eFPGA_result_a_i = 32'hDEAD_0001;
        eFPGA_result_b_i = 32'hDEAD_0002;
        eFPGA_result_c_i = 32'hDEAD_0003;
        #1;
        chk("t2_gnt", 32'(gnt_o), 32'h2);
        g = cyc;
        snap = n_en;
        push(2'b10, 1'b0, 32'hA2A2_0001, 32'hB2B2_0002, 32'hC2C2_0003);
        tick();
        req_i = 2'b00;
        chk("t2_op_a", eFPGA_operand_a_o, 32'h1111_0001);
        chk("t2_op_b", eFPGA_operand_b_o, 32'h2222_0002);
        chk("t2_operator", 32'(eFPGA_operator_o), 32'd2);
        chk("t2_delay", 32'(eFPGA_delay_o), 32'd4);
        tick();
        tick();
        tick();
        tick();
        eFPGA_result_a_i = 32'hA2A2_0001;
        eFPGA_result_b_i = 32'hB2B2_0002;
        eFPGA_result_c_i = 32'hC2C2_0003;
        wait_rv("t2", 10, g + 6);
        chk("t2_en_cycles", 32'(n_en - snap), 32'd5);
        eFPGA_result_a_i = 32'h0BAD_0BAD;
        tick();
        chk("t2_res_hold", result_a_o, 32'hA2A2_0001);

        // Round-robin with both requesters held for four operations.
        req_i = 2'b11;
        operand_a_i = {32'h0000_00A1, 32'h0000_00A0};
        operand_b_i = {32'h0000_00B1, 32'h0000_00B0};
        operator_i = {2'd3, 2'd1};
        delay_i = {4'd1, 4'd1};
        for (int i = 0; i < 4; i++) begin
            logic w;
            w = (i % 2) != 0;
            eFPGA_result_a_i = 32'h300 + 32'(i);
            eFPGA_result_b_i = 32'h400 + 32'(i);
            eFPGA_result_c_i = 32'h500 + 32'(i);
            #1;
            chk("rr_gnt", 32'(gnt_o), w ? 32'h2 : 32'h1);
            g = cyc;
            push(w ? 2'b10 : 2'b01, 1'b0, 32'h300 + 32'(i), 32'h400 + 32'(i), 32'h500 + 32'(i));
            tick();
            chk("rr_op_a", eFPGA_operand_a_o, w ? 32'hA1 : 32'hA0);
            chk("rr_operator", 32'(eFPGA_operator_o), w ? 32'd3 : 32'd1);
            wait_rv("rr", 10, g + 3);
            tick();
        end
        req_i = 2'b00;

        // Done-mode timeout: 2^3-1 = 7 WAIT cycles, results forced to zero.
        req_i = 2'b01;
        delay_i[3:0] = 4'd0;
        eFPGA_result_a_i = 32'h5555_5555;
        eFPGA_result_b_i = 32'h6666_6666;
        eFPGA_result_c_i = 32'h7777_7777;
        #1;
        chk("to_gnt", 32'(gnt_o), 32'h1);
        g = cyc;
        snap = n_en;
        push(2'b01, 1'b1, 32'd0, 32'd0, 32'd0);
        tick();
        req_i = 2'b00;
        wait_rv("to", 20, g + 9);
        chk("to_en_cycles", 32'(n_en - snap), 32'd8);
        tick();

        // Done held high through IDLE and ISSUE: still one WAIT cycle, normal completion.
        eFPGA_fpga_done_i = 1'b1;
        req_i = 2'b01;
        eFPGA_result_a_i = 32'h0000_0077;
        #1;
        chk("dn_gnt", 32'(gnt_o), 32'h1);
        g = cyc;
        push(2'b01, 1'b0, 32'h77, 32'h6666_6666, 32'h7777_7777);
        tick();
        req_i = 2'b00;
        chk("dn_no_early_rvalid", 32'(rvalid_o), 32'd0);
        tick();
        chk("dn_wait_busy", 32'(busy_o), 32'd1);
        wait_rv("dn", 10, g + 3);
        eFPGA_fpga_done_i = 1'b0;
        tick();

        // Reset in the middle of WAIT aborts silently.
        req_i = 2'b10;
        delay_i[7:4] = 4'd0;
        #1;
        chk("rw_gnt", 32'(gnt_o), 32'h2);
        tick();
        req_i = 2'b00;
        tick();
        reset = 1'b0;
        snap = n_rvalid;
        tick();
        req_i = 2'b11;
        #1;
        chk("rw_busy", 32'(busy_o), 32'd0);
        chk("rw_en", 32'(eFPGA_en_o), 32'd0);
        chk("rw_strobe", 32'(eFPGA_write_strobe_o), 32'd0);
        chk("rw_rvalid", 32'(rvalid_o), 32'd0);
        chk("rw_gnt_in_reset", 32'(gnt_o), 32'd0);
        chk("rw_res_a", result_a_o, 32'd0);
        chk("rw_op_a", eFPGA_operand_a_o, 32'd0);
        chk("rw_delay", 32'(eFPGA_delay_o), 32'd0);
        reset = 1'b1;
        req_i = 2'b00;
        tick();
        tick();
        tick();
        chk("rw_no_rvalid", 32'(n_rvalid - snap), 32'd0);
        req_i = 2'b11;
        operand_a_i[31:0] = 32'hCAFE_0000;
        delay_i[3:0] = 4'd2;
        eFPGA_result_a_i = 32'h99;
        eFPGA_result_b_i = 32'h98;
        eFPGA_result_c_i = 32'h97;
        #1;
        chk("rw_tie_gnt", 32'(gnt_o), 32'h1);
        g = cyc;
        push(2'b01, 1'b0, 32'h99, 32'h98, 32'h97);
        tick();
        req_i = 2'b00;
        chk("rw_op_a_new", eFPGA_operand_a_o, 32'hCAFE_0000);
        wait_rv("rw", 10, g + 4);
        tick();

        chk("sb_drained", 32'(sb.size()), 32'd0);
        chk("rvalid_total", 32'(n_rvalid), 32'd9);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: observed no finish expected finish");
        $fatal(1, "global timeout");
    end

endmodule
